kernel_deadlock_watchdog: RTL
=============================

# kernel_deadlock_watchdog

Parametrised deadlock watchdog for co-simulated HLS kernels, instantiated once per kernel in the simulation monitor hierarchy. It aggregates N AXI-Stream block indicators and M sub-instance idle/block flags into a qualified stall condition. It requires that condition to persist for a programmable number of cycles before declaring deadlock. On declaration it latches a sticky status, a one-cycle event and a snapshot of the culprits, and keeps a saturating count of total stalled cycles.

## Interface
Parameters:
- NUM_AXIS, 2, number of AXI-Stream channels monitored (>=1)
- NUM_INST, 1, number of sub-instances monitored (>=1)
- THRESH_W, 16, width of persistence threshold and run counter
- CNT_W, 32, width of total-stall counter

Ports:
- kernel_monitor_clock  in  1  sole clock
- kernel_monitor_reset  in  1  asynchronous, active-low reset
- axis_blk_n  in  NUM_AXIS  per-channel TDATA_blk_n, low = channel blocked
- inst_idle  in  NUM_INST  per-instance idle flag
- inst_block  in  NUM_INST  per-instance blocked flag
- enable  in  1  watchdog enable
- clear  in  1  synchronous clear of all state and status
- threshold  in  THRESH_W  consecutive stalled cycles required; 0 treated as 1
- stalled  out  1  registered stall condition
- deadlock  out  1  sticky deadlock status
- deadlock_pulse  out  1  one-cycle event on deadlock entry
- axis_snap  out  NUM_AXIS  blocked-channel mask captured at entry
- inst_snap  out  NUM_INST  blocked-instance mask captured at entry
- first_chan  out  $clog2(NUM_AXIS) (min 1)  lowest-index blocked channel at entry
- first_chan_valid  out  1  axis_snap non-zero
- stall_cycles  out  CNT_W  total stalled cycles since reset/clear, saturating

## Operation
- axis_blk = ~axis_blk_n.
- Stall condition: stall_raw = enable & (|axis_blk | |inst_block) & &(inst_idle | inst_block) & ~&inst_idle.
- States: IDLE, ARMED, DEADLOCK.
- IDLE -> ARMED when stall_raw; run_cnt <= 1.
  - If the effective threshold is 1, go directly IDLE -> DEADLOCK.
- ARMED:
  - stall_raw high: run_cnt increments, saturating at all-ones.
  - stall_raw low: return to IDLE, run_cnt <= 0.
  - When the incremented run_cnt reaches the effective threshold, go to DEADLOCK.
- Entry to DEADLOCK, same edge:
  - deadlock <= 1, deadlock_pulse <= 1.
  - axis_snap <= axis_blk, inst_snap <= inst_block.
  - first_chan <= priority-encoded axis_blk; first_chan_valid <= |axis_blk.
- DEADLOCK is sticky: stall release or enable low do not exit it; only clear or reset do.
- threshold is sampled every cycle. Lowering it below the current run_cnt while ARMED causes DEADLOCK entry on the next stalled edge.
- stall_cycles increments on every edge with stall_raw high, in any state; it saturates at 2^CNT_W-1.
- clear has priority over all updates:
  - state <= IDLE.
  - Counters, deadlock, snapshots and first_chan fields <= 0.
  - deadlock_pulse <= 0.

## Timing
- All outputs are registered. Reset value of every output and internal register is 0; state resets to IDLE.
- stalled = stall_raw delayed one cycle.
- Deadlock latency: stall_raw high at edges k .. k+T-1 (T = effective threshold) → deadlock and deadlock_pulse high after edge k+T-1.
- deadlock_pulse is high for exactly one cycle.
- Reset asserted mid-ARMED or mid-DEADLOCK: all outputs drop to 0 asynchronously. No event is emitted after release until a fresh full run of T stalled cycles.
- clear and stall_raw high on the same edge: clear wins. Counting restarts on the next edge.
- Saturated run_cnt with threshold at all-ones: entry occurs on the edge where run_cnt reaches all-ones.

## Structure
- Package kdm_pkg holds:
  - the state enum (KDM_IDLE, KDM_ARMED, KDM_DEADLOCK);
  - a width helper that returns max($clog2(n),1).
- Sub-module kdm_prio_enc, parametrised on NUM_AXIS, is a combinational lowest-index priority encoder with a valid output. The top instantiates it once.

## Test plan
- NUM_AXIS=2, threshold=4, axis_blk_n=2'b10 held for 4 cycles with inst_block=1 → deadlock and pulse after 4th edge; axis_snap=01, first_chan=0, stall_cycles=4.
- Stall for 3 cycles, release 1 cycle, stall 3 cycles, threshold=4 → no deadlock; stall_cycles=6.
- threshold=0, single stalled cycle on channel 1 → deadlock after 1 edge, first_chan=1.
- Deadlock latched, stall released, enable low → deadlock stays 1, pulse does not repeat. Then clear → all outputs 0.
- Reset asserted asynchronously in ARMED at run_cnt=3 → outputs 0 immediately. After release, the next deadlock needs a full T cycles.
- CNT_W=4, stall held 20 cycles → stall_cycles saturates at 15.

Source files
------------

// File: rtl/kernel_deadlock_watchdog_pkg.sv
// Shared types and helpers for the kernel deadlock watchdog.
package kdm_pkg;

    typedef enum logic [1:0] {
        KDM_IDLE     = 2'd0,
        KDM_ARMED    = 2'd1,
        KDM_DEADLOCK = 2'd2
    } kdm_state_e;

    // Index width for n items; a single item still needs one bit.
    function automatic int kdm_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_deadlock_watchdog_if.sv
// Monitor-side bundle: observed kernel flags and control in, watchdog status out.
// All signals are level-sampled on the rising monitor clock; there is no
// valid/ready handshake, every input is treated as valid on every edge.
interface kdm_if #(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 1,
    parameter int THRESH_W = 16,
    parameter int CNT_W    = 32
);
    localparam int FC_W = kdm_pkg::kdm_width(NUM_AXIS);

    logic [NUM_AXIS-1:0] axis_blk_n;
    logic [NUM_INST-1:0] inst_idle;
    logic [NUM_INST-1:0] inst_block;
    logic                enable;
    logic                clear;
    logic [THRESH_W-1:0] threshold;

    logic                stalled;
    logic                deadlock;
    logic                deadlock_pulse;
    logic [NUM_AXIS-1:0] axis_snap;
    logic [NUM_INST-1:0] inst_snap;
    logic [FC_W-1:0]     first_chan;
    logic                first_chan_valid;
    logic [CNT_W-1:0]    stall_cycles;
    logic [1:0]          state_dbg;

    modport master (
        output axis_blk_n, inst_idle, inst_block, enable, clear, threshold,
        input  stalled, deadlock, deadlock_pulse, axis_snap, inst_snap,
               first_chan, first_chan_valid, stall_cycles, state_dbg
    );

    modport slave (
        input  axis_blk_n, inst_idle, inst_block, enable, clear, threshold,
        output stalled, deadlock, deadlock_pulse, axis_snap, inst_snap,
               first_chan, first_chan_valid, stall_cycles, state_dbg
    );
endinterface

// File: rtl/kernel_deadlock_watchdog_prio_enc.sv
// Lowest-index-first priority encoder over the blocked-channel vector.
module kdm_prio_enc
    import kdm_pkg::*;
#(
    parameter int NUM_AXIS = 2,
    localparam int FC_W = kdm_width(NUM_AXIS)
) (
    input  logic [NUM_AXIS-1:0] vec,
    output logic [FC_W-1:0]     idx,
    output logic                valid
);
    always_comb begin
        idx   = '0;
        valid = |vec;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = FC_W'(i);
            end
        end
    end
endmodule

// File: rtl/kernel_deadlock_watchdog.sv
// Deadlock watchdog: qualifies a stall condition, requires it to persist for a
// programmable number of cycles, then latches sticky status and a culprit snapshot.
module kernel_deadlock_watchdog
    import kdm_pkg::*;
#(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 1,
    parameter int THRESH_W = 16,
    parameter int CNT_W    = 32
) (
    input logic  kernel_monitor_clock,
    input logic  kernel_monitor_reset,
    kdm_if.slave bus
);
    localparam int FC_W = kdm_width(NUM_AXIS);

    kdm_state_e          state_q, state_d;
    logic [THRESH_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic                stalled_q, stalled_d;
    logic                deadlock_q, deadlock_d;
    logic                pulse_q, pulse_d;
    logic [NUM_AXIS-1:0] axis_snap_q, axis_snap_d;
    logic [NUM_INST-1:0] inst_snap_q, inst_snap_d;
    logic [FC_W-1:0]     first_chan_q, first_chan_d;
    logic                first_valid_q, first_valid_d;

    logic [NUM_AXIS-1:0] axis_blk;
    logic                stall_raw;
    logic [THRESH_W-1:0] thr_eff;
    logic [THRESH_W-1:0] run_inc;
    logic [FC_W-1:0]     enc_idx;
    logic                enc_valid;
    logic                enter;

    assign axis_blk  = ~bus.axis_blk_n;
    // Every instance must be quiescent (idle or blocked), at least one blocked
    // or a stream blocked, and the kernel must not simply be finished (all idle).
    assign stall_raw = bus.enable
                     & ((|axis_blk) | (|bus.inst_block))
                     & (&(bus.inst_idle | bus.inst_block))
                     & ~(&bus.inst_idle);
    assign thr_eff   = (bus.threshold == '0) ? THRESH_W'(1) : bus.threshold;
    assign run_inc   = (&run_cnt_q) ? run_cnt_q : run_cnt_q + THRESH_W'(1);

    kdm_prio_enc #(.NUM_AXIS(NUM_AXIS)) u_prio_enc (
        .vec   (axis_blk),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        stall_cycles_d = stall_cycles_q;
        stalled_d      = stall_raw;
        deadlock_d     = deadlock_q;
        pulse_d        = 1'b0;
        axis_snap_d    = axis_snap_q;
        inst_snap_d    = inst_snap_q;
        first_chan_d   = first_chan_q;
        first_valid_d  = first_valid_q;
        enter          = 1'b0;

        if (stall_raw && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end

        unique case (state_q)
            KDM_IDLE: begin
                if (stall_raw) begin
                    run_cnt_d = THRESH_W'(1);
                    if (thr_eff == THRESH_W'(1)) enter = 1'b1;
                    else                         state_d = KDM_ARMED;
                end
            end
            KDM_ARMED: begin
                if (stall_raw) begin
                    run_cnt_d = run_inc;
                    // >= so a threshold lowered beneath the run fires immediately.
                    if (run_inc >= thr_eff) enter = 1'b1;
                end else begin
                    state_d   = KDM_IDLE;
                    run_cnt_d = '0;
                end
            end
            KDM_DEADLOCK: ;
            default: state_d = KDM_IDLE;
        endcase

        if (enter) begin
            state_d       = KDM_DEADLOCK;
            deadlock_d    = 1'b1;
            pulse_d       = 1'b1;
            axis_snap_d   = axis_blk;
            inst_snap_d   = bus.inst_block;
            first_chan_d  = enc_idx;
            first_valid_d = enc_valid;
        end

        if (bus.clear) begin
            state_d        = KDM_IDLE;
            run_cnt_d      = '0;
            stall_cycles_d = '0;
            stalled_d      = 1'b0;
            deadlock_d     = 1'b0;
            pulse_d        = 1'b0;
            axis_snap_d    = '0;
            inst_snap_d    = '0;
            first_chan_d   = '0;
            first_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            state_q        <= KDM_IDLE;
            run_cnt_q      <= '0;
            stall_cycles_q <= '0;
            stalled_q      <= 1'b0;
            deadlock_q     <= 1'b0;
            pulse_q        <= 1'b0;
            axis_snap_q    <= '0;
            inst_snap_q    <= '0;
            first_chan_q   <= '0;
            first_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            stalled_q      <= stalled_d;
            deadlock_q     <= deadlock_d;
            pulse_q        <= pulse_d;
            axis_snap_q    <= axis_snap_d;
            inst_snap_q    <= inst_snap_d;
            first_chan_q   <= first_chan_d;
            first_valid_q  <= first_valid_d;
        end
    end

    assign bus.stalled          = stalled_q;
    assign bus.deadlock         = deadlock_q;
    assign bus.deadlock_pulse   = pulse_q;
    assign bus.axis_snap        = axis_snap_q;
    assign bus.inst_snap        = inst_snap_q;
    assign bus.first_chan       = first_chan_q;
    assign bus.first_chan_valid = first_valid_q;
    assign bus.stall_cycles     = stall_cycles_q;
    assign bus.state_dbg        = state_q;
endmodule
